// File: rtl/div32u.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (async high), start, dividend, divisor -> busy, done, quo, rem, dbz.
module div32u #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rnew;
  logic [WIDTH-1:0] w_qnew;

  // {R,Q} << 1 keeps the bit shifted out of R in w_shift[WIDTH].
  // When R >= divisor the true difference is below 2^WIDTH,
  // so a WIDTH-bit subtract is exact.
  assign w_shift = {r_r, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_d});
  assign w_sub   = w_shift[WIDTH-1:0] - r_d;
  assign w_rnew  = w_ge ? w_sub : w_shift[WIDTH-1:0];
  assign w_qnew  = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_d   <= '0;
      r_r   <= '0;
      r_q   <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_d   <= divisor;
      r_r   <= '0;
      r_q   <= dividend;
      r_dbz <= (divisor == '0);
    end else if (r_state == S_RUN) begin
      r_r   <= w_rnew;
      r_q   <= w_qnew;
      r_cnt <= r_cnt + CW'(1);
      // Results are published only on the final step.
      if (w_last) begin
        r_quo <= w_qnew;
        r_rem <= w_rnew;
      end
    end
  end

  assign quo = r_quo;
  assign rem = r_rem;
  assign dbz = r_dbz;

endmodule

// File: doc/div32u.md
Name: div32u

Overview:
Sequential unsigned integer divider, the inverse datapath to the team's 32-bit sequential multiplier. Computes quotient and remainder of two WIDTH-bit unsigned operands by restoring division, one quotient bit per clock. Fixed latency of WIDTH cycles, with a start/busy/done handshake. Sits in the same arithmetic unit next to the multiplier and is driven by the same control logic.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a division; sampled on rising clk
dividend  input  WIDTH  numerator, captured when start is accepted
divisor  input  WIDTH  denominator, captured when start is accepted
busy  output  1  high while an iteration sequence is running
done  output  1  high while quo/rem hold a valid result
quo  output  WIDTH  quotient
rem  output  WIDTH  remainder
dbz  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset (rst=1, any time, no clock needed): state=IDLE; busy=0, done=0, dbz=0, quo=0, rem=0; iteration counter=0; internal operand registers=0. Reset during RUN abandons the operation; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E -> operands captured, partial remainder=0, quotient shift register=dividend, counter=0, dbz=(divisor==0), state=RUN, busy=1 after E.
- RUN: each edge performs one restoring step:
  - shift {R,Q} left by 1;
  - if R >= divisor, then R = R - divisor and Q[0] = 1, else Q[0] = 0.
  - Compare/subtract uses a WIDTH+1-bit intermediate; no overflow allowed.
  - Counter increments each step.
  - On the WIDTH-th step (edge E+WIDTH): quo=Q, rem=R, state=DONE, busy=0, done=1.
- Latency: start accepted at edge E; done=1 and results valid immediately after edge E+WIDTH (E+32 at default).
- DONE: done, quo, rem and dbz are held stable until the next accepted start or reset.
  - start=1 in DONE is accepted exactly as in IDLE.
  - done drops after that edge, and busy rises after that edge.
  - This allows back-to-back operations with one idle-free edge between them.
- start while busy=1 is ignored. Operands are not re-captured, and latency and result are unaffected.
- Operand inputs may change freely after acceptance; only the captured values are used.
- Divide by zero: no special-case path. Same latency as any other operation; result is the natural restoring output, quo = all ones (2^WIDTH-1) and rem = dividend. dbz=1 is held with the result; dbz is cleared on the next accepted start with nonzero divisor.
- busy and done are never high simultaneously.
- quo and rem are registered outputs. During RUN they keep the previous result (or reset value) and do not expose intermediate state.
- Invariant for divisor != 0: dividend == quo*divisor + rem, with rem < divisor.

Test Plan:
- Basic: reset, then start with dividend=100, divisor=7 -> busy for 32 cycles; done=1 at E+32 with quo=14, rem=2, dbz=0.
- Extremes: 0xFFFFFFFF/1 -> quo=0xFFFFFFFF, rem=0. Then 0x00000000/0x80000000 -> quo=0, rem=0. Then 0x7FFFFFFF/0x80000000 -> quo=0, rem=0x7FFFFFFF.
- Divide by zero: 0x12345678/0 -> done at E+32, quo=0xFFFFFFFF, rem=0x12345678, dbz=1. A following 9/3 gives quo=3, rem=0, dbz=0.
- Start while busy: start 1000/10, re-assert start with 5/5 at E+10 -> ignored; done at E+32 with quo=100, rem=0.
- Reset mid-operation: start 50/3, assert rst asynchronously (between edges) at E+15 -> outputs zero immediately, state IDLE. New start 50/3 completes 32 cycles later with quo=16, rem=2.
- Back-to-back: start held high continuously with changing operands -> each result is valid for exactly one cycle in DONE. A random 1000-vector sweep checks the invariant and latency against a reference model.
